// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH cycles,
// LSB first, with a registered carry and a start/busy/done handshake.

module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] acc_nxt;

   fullAdder u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB so bit 0 lands in acc[0] after WIDTH shifts.
   assign acc_nxt = {fa_s, acc[WIDTH-1:1]};

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= cin;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ADD;
               end
            end
            ADD: begin
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               acc   <= acc_nxt;
               carry <= fa_c;
               cnt   <= cnt + CNT_W'(1);
               // Final bit: publish the completed result on this same edge.
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  sum   <= acc_nxt;
                  cout  <= fa_c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a result scoreboard queue.

module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks;
   int errors;
   logic [WIDTH:0] exp_q[$];

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle start request and record the reference result.
   task automatic issue_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                           input logic ci);
      logic [WIDTH:0] e;
      a     = ai;
      b     = bi;
      cin   = ci;
      start = 1'b1;
      e = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, ci};
      exp_q.push_back(e);
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) for done; reports edges elapsed and busy-high samples.
   task automatic wait_done(input int limit, output int cycles, output int busy_cnt,
                            output bit ok);
      cycles   = 0;
      busy_cnt = 0;
      while (!done && cycles < limit) begin
         if (busy) busy_cnt++;
         tick();
         cycles++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      #12;
      checks++;
      if ({busy, done, cout, sum} !== {3'b000, {WIDTH{1'b0}}}) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h required 0 0 0 00",
                  busy, done, cout, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int cyc, bc; bit ok; logic [WIDTH:0] e;
      issue_op(8'h03, 8'h05, 1'b0);
      wait_done(40, cyc, bc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout: done not seen within %0d cycles", cyc);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin
         errors++;
         $display("FAIL basic_sum: got %h required %h", {cout, sum}, e);
      end
      checks++;
      if (cyc != WIDTH || bc != WIDTH) begin
         errors++;
         $display("FAIL basic_latency: got done_edge=%0d busy_cycles=%0d required %0d %0d",
                  cyc, bc, WIDTH, WIDTH);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_done_overlap: got busy=%b with done=1 required 0", busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_width: got done=%b one cycle later required 0", done);
      end
   endtask

   task automatic test_carry_out();
      logic [WIDTH-1:0] av[2];
      logic [WIDTH-1:0] bv[2];
      logic             cv[2];
      logic [WIDTH:0]   req[2];
      int cyc, bc; bit ok; logic [WIDTH:0] e;
      av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0; req[0] = 9'h100;
      av[1] = 8'hFF; bv[1] = 8'hFF; cv[1] = 1'b1; req[1] = 9'h1FF;
      for (int i = 0; i < 2; i++) begin
         issue_op(av[i], bv[i], cv[i]);
         wait_done(40, cyc, bc, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL carry_timeout_%0d: done not seen", i);
            return;
         end
         e = exp_q.pop_front();
         checks++;
         if ({cout, sum} !== e || {cout, sum} !== req[i]) begin
            errors++;
            $display("FAIL carry_sum_%0d: got %h required %h", i, {cout, sum}, req[i]);
         end
         tick();
      end
   endtask

   task automatic test_start_ignored();
      int cyc, bc, dones; bit ok; logic [WIDTH:0] e;
      issue_op(8'h10, 8'h20, 1'b0);
      cyc = 0;
      while (!done && cyc < 40) begin
         if (cyc == 3) begin
            a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL ignore_timeout: done not seen");
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin
         errors++;
         $display("FAIL ignore_sum: got %h required %h", {cout, sum}, e);
      end
      // Start during the DONE cycle must also be ignored.
      a = 8'hAA; b = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         if (done || busy) dones++;
         tick();
      end
      checks++;
      if (dones != 0 || {cout, sum} !== 9'h030) begin
         errors++;
         $display("FAIL ignore_extra: got extra_activity=%0d result=%h required 0 030",
                  dones, {cout, sum});
      end
   endtask

   task automatic test_abort();
      int cyc, bc, seen; bit ok; logic [WIDTH:0] e;
      issue_op(8'h33, 8'h44, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      exp_q.delete();
      #2;
      checks++;
      if ({busy, done, cout, sum} !== {3'b000, {WIDTH{1'b0}}}) begin
         errors++;
         $display("FAIL abort_clear: got busy=%b done=%b cout=%b sum=%h required 0 0 0 00",
                  busy, done, cout, sum);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen++;
         tick();
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (done || busy) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d activity samples required 0", seen);
      end
      issue_op(8'h7F, 8'h01, 1'b0);
      wait_done(40, cyc, bc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_restart_timeout: done not seen");
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e || {cout, sum} !== 9'h080) begin
         errors++;
         $display("FAIL abort_restart_sum: got %h required 080", {cout, sum});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc, bc, bad_sum, bad_lat; bit ok; logic [WIDTH:0] e;
      bad_sum = 0;
      bad_lat = 0;
      for (int n = 0; n < 256; n++) begin
         issue_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
         wait_done(40, cyc, bc, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout_%0d: done not seen", n);
            return;
         end
         e = exp_q.pop_front();
         checks++;
         if ({cout, sum} !== e) begin
            errors++;
            bad_sum++;
            $display("FAIL b2b_sum_%0d: got %h required %h", n, {cout, sum}, e);
         end
         checks++;
         if (cyc != WIDTH) begin
            errors++;
            bad_lat++;
            $display("FAIL b2b_latency_%0d: got %0d edges required %0d", n, cyc, WIDTH);
         end
         tick();  // DONE -> IDLE; next start lands on the first IDLE edge
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_queue: got %0d leftover entries required 0", exp_q.size());
      end
   endtask

   task automatic test_hold();
      int cyc, bc; bit ok; logic [WIDTH:0] e;
      issue_op(8'h03, 8'h05, 1'b0);
      wait_done(40, cyc, bc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL hold_timeout: done not seen");
         return;
      end
      e = exp_q.pop_front();
      tick();
      for (int i = 0; i < 20; i++) begin
         a   = WIDTH'($urandom);
         b   = WIDTH'($urandom);
         cin = 1'($urandom);
         tick();
         checks++;
         if ({cout, sum} !== e || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: got result=%h busy=%b done=%b required %h 0 0",
                     i, {cout, sum}, busy, done, e);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_carry_out();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
